// File: rtl/wb_rr_arb_wdt.sv
// Registered round-robin Wishbone arbiter with a bus-cycle watchdog that
// substitutes an ack for unanswered strobes and logs the offending master.
module wb_rr_arb_wdt #(
  parameter int unsigned N_MASTERS    = 2,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_W        = 16,
  parameter logic [15:0] ERR_CNT_INIT = '0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 bus_stb,
  input  logic                 bus_ack,
  input  logic                 wdt_en,
  output logic [N_MASTERS-1:0] gnt,
  output logic                 to_ack,
  output logic [15:0]          err_cnt,
  output logic [2:0]           err_master,
  output logic                 err_pulse
);

  localparam logic [CNT_W-1:0]     TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [N_MASTERS-1:0] GNT_RST  = N_MASTERS'(1);

  logic [CNT_W-1:0]     cnt;
  logic [2:0]           cur;
  logic                 req_cur;
  logic [N_MASTERS-1:0] gnt_next;
  logic                 gnt_chg;
  int unsigned          best_d;
  int unsigned          d;

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) cur = i[2:0];
    end
  end

  assign req_cur = |(req & gnt);

  // Rank each requester by its distance from cur+1; the nearest wins, cur itself last.
  always_comb begin
    gnt_next = gnt;
    best_d   = N_MASTERS;
    d        = 0;
    if (!req_cur) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        d = (i + N_MASTERS - 1 - int'(cur)) % N_MASTERS;
        if (req[i] && d < best_d) begin
          best_d   = d;
          gnt_next = '0;
          gnt_next[i] = 1'b1;
        end
      end
    end
  end

  assign gnt_chg = (gnt_next != gnt);

  assign to_ack = !sys_rst && wdt_en && req_cur && bus_stb && !bus_ack && (cnt == TO_VAL);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt        <= GNT_RST;
      cnt        <= '0;
      err_cnt    <= ERR_CNT_INIT;
      err_master <= '0;
      err_pulse  <= 1'b0;
    end else begin
      gnt <= gnt_next;
      if (!wdt_en || bus_ack || !bus_stb || !req_cur || gnt_chg)
        cnt <= '0;
      else if (to_ack)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      err_pulse <= to_ack;
      if (to_ack) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        err_master <= cur;
      end
    end
  end

endmodule
